fetch_sequencer: RTL and testbench

- Instruction sequencer that sits in front of the existing control unit.
- Fetches 16-bit instructions from program memory over a req/ack handshake and presents each ALU instruction to the control unit (d_in/run).
- Waits for the control unit's done, then advances the PC.
- Executes branch and halt instructions itself, using the datapath zero flag, and reports errors and retired-instruction count.

---
 rtl/fetch_sequencer_if.sv | 24 ++
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Program-memory read channel and control-unit channel of the fetch sequencer.
// master = sequencer side, slave = memory / control unit / datapath side.
interface fetch_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [15:0]       mem_rdata;
   logic [15:0]       instr;
   logic              run;
   logic              cu_done;
   logic              alu_zero;

   modport master (
      output mem_req, mem_addr, instr, run,
      input  mem_ack, mem_rdata, cu_done, alu_zero
   );

   modport slave (
      input  mem_req, mem_addr, instr, run,
      output mem_ack, mem_rdata, cu_done, alu_zero
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetches 16-bit instructions, hands ALU ops to the control unit and executes branch/halt itself.
// ALU op: 1 + mem latency + 4 cycles; branch: 1 + mem latency + 1; mem_req held until mem_ack, run until cu_done.
module fetch_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   fetch_sequencer_if.master bus,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              error,
   output logic [15:0]       instr_count
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      EXEC   = 3'd2,
      BRANCH = 3'd3,
      HALT   = 3'd4,
      ERROR  = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WD_W-1:0]   watchdog;
   logic [1:0]        cond;
   logic [ADDR_W-1:0] target;
   logic              take;
   logic              wd_expired;

   assign cond       = bus.instr[3:2];
   assign target     = bus.instr[ADDR_W+3:4];
   assign take       = (cond == 2'b00) ||
                       ((cond == 2'b01) &&  bus.alu_zero) ||
                       ((cond == 2'b10) && !bus.alu_zero);
   assign wd_expired = (watchdog == WD_W'(TIMEOUT - 1));

   assign bus.mem_addr = pc;
   assign busy   = (state == FETCH) || (state == EXEC) || (state == BRANCH);
   assign halted = (state == HALT);
   assign error  = (state == ERROR);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, HALT, ERROR: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            if (bus.mem_ack) begin
               case (bus.mem_rdata[1:0])
                  2'b00:   state_nxt = EXEC;
                  2'b10:   state_nxt = BRANCH;
                  default: state_nxt = ERROR;
               endcase
            end
         end
         EXEC: begin
            if (bus.cu_done)     state_nxt = FETCH;
            else if (wd_expired) state_nxt = ERROR;
         end
         BRANCH: begin
            state_nxt = (cond == 2'b11) ? HALT : FETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // mem_req/run follow the next state so both are registered yet valid on the first cycle of FETCH/EXEC.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc          <= '0;
         bus.instr   <= '0;
         bus.run     <= 1'b0;
         bus.mem_req <= 1'b0;
         instr_count <= '0;
         watchdog    <= '0;
      end else begin
         bus.mem_req <= (state_nxt == FETCH);
         bus.run     <= (state_nxt == EXEC);
         case (state)
            IDLE, HALT, ERROR: begin
               if (start) pc <= '0;
            end
            FETCH: begin
               if (bus.mem_ack) bus.instr <= bus.mem_rdata;
            end
            EXEC: begin
               if (bus.cu_done) begin
                  pc       <= pc + ADDR_W'(1);
                  watchdog <= '0;
                  if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
               end else if (wd_expired) begin
                  watchdog <= '0;
               end else begin
                  watchdog <= watchdog + WD_W'(1);
               end
            end
            BRANCH: begin
               if (cond != 2'b11) pc <= take ? target : pc + ADDR_W'(1);
               if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: single-instruction vector table plus multi-cycle sequences.
module tb_fetch_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        start;
   logic        start2;
   logic [7:0]  pc;
   logic        busy, halted, error;
   logic [15:0] instr_count;
   logic [1:0]  pc2;
   logic        busy2, halted2, error2;
   logic [15:0] count2;

   fetch_sequencer_if #(.ADDR_W(8)) bus ();
   fetch_sequencer_if #(.ADDR_W(2)) bus2 ();

   fetch_sequencer #(.ADDR_W(8), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .start(start), .bus(bus),
      .pc(pc), .busy(busy), .halted(halted), .error(error), .instr_count(instr_count)
   );

   fetch_sequencer #(.ADDR_W(2), .TIMEOUT(15)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .bus(bus2),
      .pc(pc2), .busy(busy2), .halted(halted2), .error(error2), .instr_count(count2)
   );

   logic [15:0] prog [256];
   logic [15:0] prog2 [4];
   int          mem_lat;
   logic        cu_hang;
   int          mcnt, rcnt, mcnt2, rcnt2;

   // Memory answers after mem_lat waiting cycles; control unit raises done in the 4th run cycle.
   always @(negedge clk) begin
      if (bus.mem_req) begin
         if (mcnt >= mem_lat) begin
            bus.mem_ack = 1'b1; bus.mem_rdata = prog[bus.mem_addr]; mcnt = 0;
         end else begin
            bus.mem_ack = 1'b0; bus.mem_rdata = 16'hDEAD; mcnt++;
         end
      end else begin
         bus.mem_ack = 1'b0; bus.mem_rdata = 16'hDEAD; mcnt = 0;
      end
      if (bus.run && !cu_hang) begin
         rcnt++; bus.cu_done = (rcnt == 4);
      end else begin
         rcnt = 0; bus.cu_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (bus2.mem_req) begin
         bus2.mem_ack = 1'b1; bus2.mem_rdata = prog2[bus2.mem_addr]; mcnt2 = 0;
      end else begin
         bus2.mem_ack = 1'b0; bus2.mem_rdata = 16'hDEAD; mcnt2 = 0;
      end
      if (bus2.run) begin
         rcnt2++; bus2.cu_done = (rcnt2 == 4);
      end else begin
         rcnt2 = 0; bus2.cu_done = 1'b0;
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      start = 1'b0;
      start2 = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   typedef struct {
      logic [15:0] w;
      logic        z;
      int          lat;
      logic        hang;
      logic [7:0]  pc;
      logic [15:0] cnt;
      int          nrun;
      int          nreq;
      logic        hlt;
      logic        err;
   } vec_t;

   vec_t vecs [13];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   nrun, nreq, nfetch;
      logic prev, done, ok;

      //          word      z  lat hang pc    cnt  run req hlt err
      vecs[0]  = '{16'h0000, 0, 0, 0, 8'd1,   1,  4,  1,  0, 0};
      vecs[1]  = '{16'h0000, 0, 2, 0, 8'd1,   1,  4,  3,  0, 0};
      vecs[2]  = '{16'h0052, 0, 0, 0, 8'd5,   1,  0,  1,  0, 0};
      vecs[3]  = '{16'h0036, 0, 0, 0, 8'd1,   1,  0,  1,  0, 0};
      vecs[4]  = '{16'h0036, 1, 0, 0, 8'd3,   1,  0,  1,  0, 0};
      vecs[5]  = '{16'h007A, 0, 0, 0, 8'd7,   1,  0,  1,  0, 0};
      vecs[6]  = '{16'h007A, 1, 0, 0, 8'd1,   1,  0,  1,  0, 0};
      vecs[7]  = '{16'h0FF2, 0, 0, 0, 8'd255, 1,  0,  1,  0, 0};
      vecs[8]  = '{16'h000E, 0, 0, 0, 8'd0,   1,  0,  1,  1, 0};
      vecs[9]  = '{16'h0001, 0, 0, 0, 8'd0,   0,  0,  1,  0, 1};
      vecs[10] = '{16'h0003, 0, 1, 0, 8'd0,   0,  0,  2,  0, 1};
      vecs[11] = '{16'h0000, 0, 0, 1, 8'd0,   0, 15,  1,  0, 1};
      vecs[12] = '{16'h00FE, 1, 0, 0, 8'd0,   1,  0,  1,  1, 0};

      reset = 1'b1; start = 1'b0; start2 = 1'b0;
      bus.alu_zero = 1'b0; bus2.alu_zero = 1'b0;
      mem_lat = 0; cu_hang = 1'b0;
      for (int a = 0; a < 256; a++) prog[a] = 16'h000E;
      prog2[0] = 16'h0032; prog2[1] = 16'h000E; prog2[2] = 16'h000E; prog2[3] = 16'h0000;

      // Reset values, with start held high during reset
      #2 reset = 1'b0;
      start = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pc", pc, 0);
      check("rst_instr", bus.instr, 0);
      check("rst_run", bus.run, 0);
      check("rst_mem_req", bus.mem_req, 0);
      check("rst_count", instr_count, 0);
      check("rst_busy", busy, 0);
      check("rst_halted", halted, 0);
      check("rst_error", error, 0);
      start = 1'b0;

      // Table of single-instruction programs
      for (int i = 0; i < 13; i++) begin
         do_reset();
         for (int a = 0; a < 256; a++) prog[a] = 16'h000E;
         prog[0] = vecs[i].w;
         bus.alu_zero = vecs[i].z;
         mem_lat = vecs[i].lat;
         cu_hang = vecs[i].hang;
         nrun = 0; nreq = 0; nfetch = 0; prev = 1'b0; done = 1'b0;
         start = 1'b1;
         for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (bus.run) nrun++;
            if (bus.mem_req && !prev) nfetch++;
            if (nfetch == 1 && bus.mem_req) nreq++;
            prev = bus.mem_req;
            if (nfetch == 2 || halted || error) done = 1'b1;
         end
         check($sformatf("v%0d_finished", i), done, 1);
         check($sformatf("v%0d_pc", i), pc, vecs[i].pc);
         check($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].pc);
         check($sformatf("v%0d_count", i), instr_count, vecs[i].cnt);
         check($sformatf("v%0d_run_cycles", i), nrun, vecs[i].nrun);
         check($sformatf("v%0d_req_cycles", i), nreq, vecs[i].nreq);
         check($sformatf("v%0d_halted", i), halted, vecs[i].hlt);
         check($sformatf("v%0d_error", i), error, vecs[i].err);
         check($sformatf("v%0d_busy", i), busy, !(vecs[i].hlt || vecs[i].err));
         check($sformatf("v%0d_run_end", i), bus.run, 0);
      end
      cu_hang = 1'b0;
      bus.alu_zero = 1'b0;

      // Delayed ack: instr only captured on the ack cycle, address stable meanwhile
      do_reset();
      prog[0] = 16'h1230;
      mem_lat = 2;
      start = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         check($sformatf("lat_req_c%0d", c), bus.mem_req, 1);
         check($sformatf("lat_addr_c%0d", c), bus.mem_addr, 0);
         check($sformatf("lat_instr_hold_c%0d", c), bus.instr, 0);
      end
      @(posedge clk); #1;
      check("lat_req_drop", bus.mem_req, 0);
      check("lat_instr_cap", bus.instr, 16'h1230);
      check("lat_run", bus.run, 1);
      repeat (2) @(posedge clk);
      #1 check("lat_instr_stable", bus.instr, 16'h1230);
      mem_lat = 0;

      // Run to HALT, start ignored mid-EXEC, then restart from address 0
      do_reset();
      for (int a = 0; a < 256; a++) prog[a] = 16'h000E;
      prog[0] = 16'h0000; prog[1] = 16'h0000; prog[2] = 16'h000E;
      start = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         ok = bus.run && (pc == 8'd1);
      end
      check("seq_exec_pc1", ok, 1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("seq_start_ignored", pc, 1);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(posedge clk); #1;
         ok = halted;
      end
      check("seq_halt_reached", ok, 1);
      check("seq_halt_pc", pc, 2);
      check("seq_halt_count", instr_count, 3);
      check("seq_halt_busy", busy, 0);
      check("seq_halt_req", bus.mem_req, 0);
      check("seq_halt_instr", bus.instr, 16'h000E);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("seq_restart_req", bus.mem_req, 1);
      check("seq_restart_addr", bus.mem_addr, 0);
      check("seq_restart_busy", busy, 1);
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(posedge clk); #1;
         ok = halted;
      end
      check("seq_rehalt_reached", ok, 1);
      check("seq_rehalt_count", instr_count, 6);
      check("seq_rehalt_pc", pc, 2);

      // pc wrap with a 2-bit address: branch to 3, ALU at 3, pc becomes 0
      do_reset();
      start2 = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(posedge clk); #1;
         start2 = 1'b0;
         ok = bus2.run;
      end
      check("wrap_exec_seen", ok, 1);
      check("wrap_exec_pc", pc2, 3);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(posedge clk); #1;
         ok = !bus2.run;
      end
      check("wrap_done_seen", ok, 1);
      check("wrap_pc", pc2, 0);
      check("wrap_count", count2, 2);
      check("wrap_refetch_addr", bus2.mem_addr, 0);
      check("wrap_refetch_req", bus2.mem_req, 1);
      check("wrap_error", error2, 0);

      // Asynchronous reset in the middle of EXEC
      do_reset();
      for (int a = 0; a < 256; a++) prog[a] = 16'h0000;
      start = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         ok = bus.run && (pc == 8'd1);
      end
      check("arst_exec_pc1", ok, 1);
      @(posedge clk); #1;
      #2 reset = 1'b0;
      #1;
      check("arst_run", bus.run, 0);
      check("arst_pc", pc, 0);
      check("arst_busy", busy, 0);
      check("arst_count", instr_count, 0);
      check("arst_instr", bus.instr, 0);
      check("arst_req", bus.mem_req, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("arst_stays_idle", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
